// File: rtl/jk_q_monitor.sv
// jk_q_monitor: observes the JK flip-flop output Q in its own clock domain.
// Detects rising/falling edges, counts them, and measures the length of each
// completed high/low run.  Completed runs are offered through a one-deep
// valid/ready output register; a run that cannot be stored sets a sticky
// overflow flag.
module jk_q_monitor #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             en,
    input  logic             clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [LEN_W-1:0] run_len,
    output logic             run_lvl,
    output logic             run_valid,
    input  logic             run_ready,
    output logic             overflow
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    // Run-length increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        if (v == LEN_MAX) begin
            return v;
        end
        return v + LEN_W'(1);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_run_cnt;
    logic [LEN_W-1:0] w_run_cnt_nxt;
    logic             r_q_d;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [LEN_W-1:0] r_run_len;
    logic             r_run_lvl;
    logic             r_run_valid;
    logic             r_overflow;

    logic             w_edge;
    logic             w_xfer;
    logic             w_capture;
    logic             w_accept;
    logic             w_drop;

    // An edge only counts while the monitor is enabled; clr suppresses any
    // capture so that it wins over a simultaneous run completion.
    assign w_edge    = en & (q_in ^ r_q_d);
    assign w_xfer    = r_run_valid & run_ready;
    assign w_capture = (r_state == ST_MEASURE) & w_edge & ~clr;
    assign w_accept  = w_capture & (~r_run_valid | run_ready);
    assign w_drop    = w_capture & r_run_valid & ~run_ready;

    // Delayed copy of Q used for edge detection; runs even while disabled so
    // re-enabling never sees a stale level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_d <= 1'b0;
        end else begin
            r_q_d <= q_in;
        end
    end

    // FSM state and run-length counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

    // Next-state logic: IDLE waits for the first edge (whose preceding run has
    // unknown length), MEASURE counts cycles since the last edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_cnt_nxt = r_run_cnt;
        if (clr || !en) begin
            w_state_nxt   = ST_IDLE;
            w_run_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        w_state_nxt   = ST_MEASURE;
                        w_run_cnt_nxt = LEN_W'(1);
                    end else begin
                        w_run_cnt_nxt = '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        w_run_cnt_nxt = LEN_W'(1);
                    end else begin
                        w_run_cnt_nxt = sat_inc(r_run_cnt);
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_run_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Single-cycle edge pulses, direction given by the new level of Q.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_edge & q_in;
            r_fall <= w_edge & ~q_in;
        end
    end

    // Wrapping count of every detected edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_edge_cnt <= '0;
        end else if (w_edge) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
    end

    // One-deep output record: a capture replaces the record only when the slot
    // is free or being drained this cycle; otherwise the new run is lost and
    // overflow latches.  Held data never changes while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_len   <= '0;
            r_run_lvl   <= 1'b0;
            r_run_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_run_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_run_valid <= 1'b1;
                r_run_len   <= r_run_cnt;
                r_run_lvl   <= r_q_d;
            end else if (w_xfer) begin
                r_run_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign edge_cnt   = r_edge_cnt;
    assign run_len    = r_run_len;
    assign run_lvl    = r_run_lvl;
    assign run_valid  = r_run_valid;
    assign overflow   = r_overflow;

endmodule
